// File: rtl/por_release_sequencer_pkg.sv
// Shared state encodings and default constants for the power-on reset release sequencer.
// The optional startup watchdog is enabled with the POR_SEQ_TIMEOUT_EN macro.
package por_release_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_EDGE = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 200;
    localparam int DEF_CNT_W          = 8;

    // True when a limit can be reached by a cnt_w-bit counter without wrapping.
    function automatic bit cnt_fits(input int cnt_w, input int limit);
        return (limit >= 1) && (longint'(limit) < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/por_release_sequencer_edge_detect.sv
// Polarity-selectable edge detector on the registered ladder output; the first clock
// after reset only primes the history flop so a level present at reset is never an edge.
module startup_edge_detect
    import por_release_sequencer_pkg::*;
#(
    parameter bit EDGE_POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic edge_i,
    output logic det_o,
    output logic primed_o
);

    logic edge_q;
    logic primed_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            edge_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            edge_q   <= edge_i;
            primed_q <= 1'b1;
        end
    end

    assign det_o    = primed_q & (edge_i == EDGE_POL) & (edge_q != EDGE_POL);
    assign primed_o = primed_q;

endmodule

// File: rtl/por_release_sequencer.sv
// Waits for the ladder startup edge, holds off HOLD_CYCLES clocks, then releases the
// downstream reset with a one-cycle startup pulse. POR_SEQ_TIMEOUT_EN adds a watchdog.
module por_release_sequencer
    import por_release_sequencer_pkg::*;
#(
    parameter bit EDGE_POL       = 1'b1,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       edge_i,
    output logic       rst_out_n,
    output logic       startup_pulse,
    output logic       ready,
    output logic [1:0] state_o,
    output logic       timeout_flag
);

    if (!cnt_fits(CNT_W, HOLD_CYCLES) || !cnt_fits(CNT_W, TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("por_release_sequencer: CNT_W too narrow for HOLD_CYCLES/TIMEOUT_CYCLES");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic det;
    logic primed;

    startup_edge_detect #(
        .EDGE_POL (EDGE_POL)
    ) u_edge_detect (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .edge_i   (edge_i),
        .det_o    (det),
        .primed_o (primed)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rst_out_q;
    logic             pulse_q;
    logic             ready_q;

`ifdef POR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic tflag_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT_EDGE;
            cnt_q     <= '0;
            rst_out_q <= 1'b0;
            pulse_q   <= 1'b0;
            ready_q   <= 1'b0;
`ifdef POR_SEQ_TIMEOUT_EN
            tflag_q   <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_WAIT_EDGE: begin
                    if (ena && primed) begin
                        if (det) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= '0;
                        end
`ifdef POR_SEQ_TIMEOUT_EN
                        // Watchdog: no edge seen within the limit forces the release.
                        else if (cnt_q == TO_LAST) begin
                            state_q   <= ST_RELEASE;
                            rst_out_q <= 1'b1;
                            pulse_q   <= 1'b1;
                            tflag_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
`ifdef POR_SEQ_TIMEOUT_EN
                    else if (det) begin
                        cnt_q <= '0;
                    end
`endif
                end
                ST_HOLD: begin
                    // ena low freezes the count; it resumes where it stopped.
                    if (ena) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q   <= ST_RELEASE;
                            rst_out_q <= 1'b1;
                            pulse_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign rst_out_n     = rst_out_q;
    assign startup_pulse = pulse_q;
    assign ready         = ready_q;
    assign state_o       = state_q;

`ifdef POR_SEQ_TIMEOUT_EN
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_por_release_sequencer.sv
// Directed bench for por_release_sequencer: a rising-edge instance with default hold and a
// falling-edge instance with HOLD_CYCLES=1, checked against queued expected release cycles.
module tb_por_release_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       edge_m;
    logic       edge_f;

    logic       rst_out_m, pulse_m, ready_m, tflag_m;
    logic [1:0] state_m;
    logic       rst_out_f, pulse_f, ready_f, tflag_f;
    logic [1:0] state_f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    logic [31:0] exp_m_q[$];
    logic [31:0] exp_f_q[$];

    por_release_sequencer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .edge_i        (edge_m),
        .rst_out_n     (rst_out_m),
        .startup_pulse (pulse_m),
        .ready         (ready_m),
        .state_o       (state_m),
        .timeout_flag  (tflag_m)
    );

    por_release_sequencer #(
        .EDGE_POL    (1'b0),
        .HOLD_CYCLES (1)
    ) u_dut_fall (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .edge_i        (edge_f),
        .rst_out_n     (rst_out_f),
        .startup_pulse (pulse_f),
        .ready         (ready_f),
        .state_o       (state_f),
        .timeout_flag  (tflag_f)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to #1 after edge n, counted from the last reset release.
    task automatic tick_to(input int n);
        while ((cyc - base) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rst_out_m", rst_out_m, 0);
        chk("rst_pulse_m",   pulse_m,   0);
        chk("rst_ready_m",   ready_m,   0);
        chk("rst_state_m",   state_m,   0);
        chk("rst_tflag_m",   tflag_m,   0);
        chk("rst_rst_out_f", rst_out_f, 0);
        chk("rst_pulse_f",   pulse_f,   0);
        chk("rst_ready_f",   ready_f,   0);
        chk("rst_state_f",   state_f,   0);
        chk("rst_tflag_f",   tflag_f,   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;
    endtask

    // Wait for a startup pulse, pop the expected release edge and compare.
    task automatic wait_pulse(input bit sel, input int budget);
        bit          seen;
        logic [31:0] expv;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((sel ? pulse_f : pulse_m) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(sel ? "pulse_seen_f" : "pulse_seen_m", {31'b0, seen}, 1);
        if (sel) expv = (exp_f_q.size() > 0) ? exp_f_q.pop_front() : 32'hffff_ffff;
        else     expv = (exp_m_q.size() > 0) ? exp_m_q.pop_front() : 32'hffff_ffff;
        if (seen) begin
            chk(sel ? "release_edge_f" : "release_edge_m", cyc - base, expv);
            chk(sel ? "release_rst_f" : "release_rst_m", sel ? rst_out_f : rst_out_m, 1);
            chk(sel ? "release_state_f" : "release_state_m", sel ? state_f : state_m, 2);
            @(negedge clk);
            chk(sel ? "pulse_width_f" : "pulse_width_m", sel ? pulse_f : pulse_m, 0);
            chk(sel ? "ready_f" : "ready_m", sel ? ready_f : ready_m, 1);
            chk(sel ? "run_state_f" : "run_state_m", sel ? state_f : state_m, 3);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        edge_m = 1'b0;
        edge_f = 1'b0;
        #2;

        // Nominal rising edge at edge 5, and falling instance with HOLD_CYCLES=1
        apply_reset();
        tick_to(3);
        edge_f = 1'b1;
        tick_to(5);
        edge_m = 1'b1;
        exp_m_q.push_back(22);
        tick_to(9);
        chk("fall_rise_ignored", state_f, 0);
        chk("hold_state_m", state_m, 1);
        chk("hold_rst_out_m", rst_out_m, 0);
        tick_to(10);
        edge_f = 1'b0;
        exp_f_q.push_back(12);
        wait_pulse(1'b1, 10);
        wait_pulse(1'b0, 20);

        // Edges in RUN are ignored
        @(posedge clk); #1;
        edge_m = 1'b0;
        tick_to(cyc - base + 2);
        edge_m = 1'b1;
        tick_to(cyc - base + 3);
        chk("run_edge_state", state_m, 3);
        chk("run_edge_pulse", pulse_m, 0);
        chk("run_edge_rst_out", rst_out_m, 1);

        // Level already high through reset; real transition at edge 40
        apply_reset();
        tick_to(38);
        chk("level_state", state_m, 0);
        chk("level_rst_out", rst_out_m, 0);
        edge_m = 1'b0;
        tick_to(40);
        edge_m = 1'b1;
        exp_m_q.push_back(57);
        wait_pulse(1'b0, 30);
        chk("level_tflag", tflag_m, 0);

        // ena low for 4 cycles after 6 hold counts delays release by 4
        edge_m = 1'b0;
        apply_reset();
        tick_to(5);
        edge_m = 1'b1;
        exp_m_q.push_back(26);
        tick_to(12);
        ena = 1'b0;
        tick_to(16);
        chk("freeze_state", state_m, 1);
        ena = 1'b1;
        wait_pulse(1'b0, 30);

        // Reset in the middle of HOLD, then a fresh edge needs the full hold
        edge_m = 1'b0;
        apply_reset();
        tick_to(5);
        edge_m = 1'b1;
        tick_to(16);
        chk("mid_hold_state", state_m, 1);
        #2;
        apply_reset();
        tick_to(3);
        chk("after_rst_level_state", state_m, 0);
        edge_m = 1'b0;
        tick_to(5);
        edge_m = 1'b1;
        exp_m_q.push_back(22);
        wait_pulse(1'b0, 30);

`ifdef POR_SEQ_TIMEOUT_EN
        // Watchdog: no edge forces release; flag is sticky
        edge_m = 1'b0;
        apply_reset();
        exp_m_q.push_back(201);
        wait_pulse(1'b0, 260);
        chk("wd_tflag", tflag_m, 1);
        tick_to(cyc - base + 5);
        chk("wd_tflag_sticky", tflag_m, 1);
        chk("wd_state", state_m, 3);

        // Edge before the limit gives a normal release
        apply_reset();
        tick_to(50);
        edge_m = 1'b1;
        exp_m_q.push_back(67);
        wait_pulse(1'b0, 40);
        chk("wd_edge_tflag", tflag_m, 0);
`endif

        chk("exp_q_drained", exp_m_q.size() + exp_f_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
